// File: rtl/sokoban_pkg.sv
// sokoban_pkg: shared renderer FSM encoding and tile geometry.
// Imported by the tilemap renderer and its request queue.
package sokoban_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_RDWAIT,
    S_ISSUE,
    S_ACK,
    S_DRAW,
    S_NEXT
  } rstate_e;

  localparam int TILE_SHIFT = 2;

endpackage

// File: rtl/tile_req_fifo.sv
// tile_req_fifo: small FIFO of pending single-tile redraw coordinates.
// A push into a full queue is accepted when a pop happens in the same cycle.
module tile_req_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  logic          do_push, do_pop;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem_q[rd_q];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + (AW+1)'(do_push)
                     - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_q] <= din;
  end

endmodule

// File: rtl/tilemap_renderer.sv
// tilemap_renderer: walks the tile map and issues sprite draws,
// either a whole-grid pass or queued single-tile redraws.
module tilemap_renderer
  import sokoban_pkg::*;
#(
  parameter int COLS       = 16,
  parameter int ROWS       = 8,
  parameter int TILE_LOG2  = TILE_SHIFT,
  parameter int ID_W       = 4,
  parameter int QDEPTH     = 4,
  parameter int SKIP_BLANK = 0,
  parameter int BLANK_ID   = 0,
  localparam int CW = $clog2(COLS + 1),
  localparam int RW = $clog2(ROWS + 1),
  localparam int AW = $clog2(COLS * ROWS)
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            full_redraw,
  input  logic            tile_redraw,
  input  logic [CW-1:0]   tile_col,
  input  logic [RW-1:0]   tile_row,
  output logic [AW-1:0]   map_addr,
  input  logic [ID_W-1:0] map_data,
  output logic [7:0]      spr_x,
  output logic [6:0]      spr_y,
  output logic [ID_W-1:0] spr_id,
  output logic            spr_start,
  input  logic            spr_busy,
  output logic            busy,
  output logic            pass_done,
  output logic            q_overflow
);

  rstate_e         state_q;
  logic [CW-1:0]   col_q;
  logic [RW-1:0]   row_q;
  logic            full_q;
  logic            pend_q, pend_d;
  logic [AW-1:0]   map_addr_q;
  logic [7:0]      spr_x_q;
  logic [6:0]      spr_y_q;
  logic [ID_W-1:0] spr_id_q;
  logic            spr_start_q;
  logic            pass_done_q;
  logic            q_ovf_q;

  logic            idle, start_full, in_rng;
  logic            q_push, q_pop, q_full, q_empty;
  logic [CW-1:0]   q_col;
  logic [RW-1:0]   q_row;
  logic            last_tile, blank;

  function automatic logic [AW-1:0] addr_of(
    input logic [CW-1:0] c,
    input logic [RW-1:0] r
  );
    return AW'(r) * AW'(COLS) + AW'(c);
  endfunction

  assign idle       = (state_q == S_IDLE);
  assign start_full = idle && (pend_q || full_redraw);
  assign in_rng     = (tile_col < CW'(COLS))
                   && (tile_row < RW'(ROWS));
  assign q_pop      = idle && !start_full && !q_empty;
  // a tile request alongside an accepted pass is already covered by it
  assign q_push     = tile_redraw && in_rng
                   && !full_redraw && !start_full;
  assign last_tile  = (col_q == CW'(COLS - 1))
                   && (row_q == RW'(ROWS - 1));
  assign blank      = (SKIP_BLANK != 0)
                   && (map_data == ID_W'(BLANK_ID));

  always_comb begin
    pend_d = pend_q;
    if (start_full)       pend_d = 1'b0;
    else if (full_redraw) pend_d = 1'b1;
  end

  tile_req_fifo #(
    .DEPTH (QDEPTH),
    .W     (CW + RW)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (q_push),
    .pop    (q_pop),
    .flush  (start_full),
    .din    ({tile_col, tile_row}),
    .dout   ({q_col, q_row}),
    .full   (q_full),
    .empty  (q_empty)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      col_q       <= '0;
      row_q       <= '0;
      full_q      <= 1'b0;
      pend_q      <= 1'b0;
      map_addr_q  <= '0;
      spr_x_q     <= '0;
      spr_y_q     <= '0;
      spr_id_q    <= '0;
      spr_start_q <= 1'b0;
      pass_done_q <= 1'b0;
      q_ovf_q     <= 1'b0;
    end else begin
      spr_start_q <= 1'b0;
      pass_done_q <= 1'b0;
      pend_q      <= pend_d;
      if (q_push && q_full && !q_pop) q_ovf_q <= 1'b1;
      unique case (state_q)
        S_IDLE: begin
          if (start_full) begin
            full_q     <= 1'b1;
            col_q      <= '0;
            row_q      <= '0;
            map_addr_q <= '0;
            state_q    <= S_FETCH;
          end else if (!q_empty) begin
            full_q     <= 1'b0;
            col_q      <= q_col;
            row_q      <= q_row;
            map_addr_q <= addr_of(q_col, q_row);
            state_q    <= S_FETCH;
          end
        end
        S_FETCH: state_q <= S_RDWAIT;
        S_RDWAIT: begin
          spr_id_q <= map_data;
          if (blank) begin
            state_q <= S_NEXT;
          end else begin
            spr_x_q     <= 8'(col_q) << TILE_LOG2;
            spr_y_q     <= 7'(row_q) << TILE_LOG2;
            spr_start_q <= 1'b1;
            state_q     <= S_ISSUE;
          end
        end
        S_ISSUE: state_q <= S_ACK;
        S_ACK: begin
          if (spr_busy) state_q <= S_DRAW;
        end
        S_DRAW: begin
          if (!spr_busy) state_q <= S_NEXT;
        end
        S_NEXT: begin
          if (!full_q || last_tile) begin
            pass_done_q <= 1'b1;
            state_q     <= S_IDLE;
          end else begin
            // row-major walk keeps the map address a simple increment
            if (col_q == CW'(COLS - 1)) begin
              col_q <= '0;
              row_q <= row_q + RW'(1);
            end else begin
              col_q <= col_q + CW'(1);
            end
            map_addr_q <= map_addr_q + AW'(1);
            state_q    <= S_FETCH;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign map_addr   = map_addr_q;
  assign spr_x      = spr_x_q;
  assign spr_y      = spr_y_q;
  assign spr_id     = spr_id_q;
  assign spr_start  = spr_start_q;
  assign busy       = !idle;
  assign pass_done  = pass_done_q;
  assign q_overflow = q_ovf_q;

endmodule

// File: tb/tb_tilemap_renderer.sv
// tb_tilemap_renderer: randomized bench for tilemap_renderer with a
// map RAM, a sprite drawer responder and an expected-draw reference list.
module tb_tilemap_renderer;

  localparam int COLS = 16;
  localparam int ROWS = 8;
  localparam int TL   = 2;
  localparam int NT   = COLS * ROWS;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       full_redraw = 1'b0;
  logic       tile_redraw = 1'b0;
  logic [4:0] tile_col = '0;
  logic [3:0] tile_row = '0;
  logic [6:0] map_addr;
  logic [3:0] map_data;
  logic [7:0] spr_x;
  logic [6:0] spr_y;
  logic [3:0] spr_id;
  logic       spr_start;
  logic       spr_busy;
  logic       busy;
  logic       pass_done;
  logic       q_overflow;

  int n_cmp = 0;
  int n_err = 0;

  tilemap_renderer #(
    .SKIP_BLANK (1),
    .BLANK_ID   (0)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .full_redraw (full_redraw),
    .tile_redraw (tile_redraw),
    .tile_col    (tile_col),
    .tile_row    (tile_row),
    .map_addr    (map_addr),
    .map_data    (map_data),
    .spr_x       (spr_x),
    .spr_y       (spr_y),
    .spr_id      (spr_id),
    .spr_start   (spr_start),
    .spr_busy    (spr_busy),
    .busy        (busy),
    .pass_done   (pass_done),
    .q_overflow  (q_overflow)
  );

  always #5 clk = ~clk;

  logic [3:0] mem [NT];
  always @(posedge clk) map_data <= mem[map_addr];

  int drw_cnt = 0;
  int drw_fix = 0;
  always @(posedge clk) begin
    if (spr_start)
      drw_cnt <= (drw_fix > 0) ? drw_fix : int'($urandom_range(1, 3));
    else if (drw_cnt > 0)
      drw_cnt <= drw_cnt - 1;
  end
  assign spr_busy = (drw_cnt != 0);

  function automatic logic [31:0] rec(
    input logic [7:0] x, input logic [6:0] y, input logic [3:0] id);
    return {13'd0, x, y, id};
  endfunction

  logic [31:0] obq [$];
  int pd_cnt = 0;
  always @(negedge clk) begin
    if (spr_start) obq.push_back(rec(spr_x, spr_y, spr_id));
    if (pass_done) pd_cnt++;
  end

  logic [31:0] exq [$];

  function automatic void exp_tile(input int c, input int r);
    logic [3:0] id;
    id = mem[r * COLS + c];
    if (id != 4'd0)
      exq.push_back(rec(8'(c * (1 << TL)), 7'(r * (1 << TL)), id));
  endfunction

  function automatic void exp_pass();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        exp_tile(c, r);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic fill_map(input int zero_pct);
    for (int i = 0; i < NT; i++)
      mem[i] = (int'($urandom_range(0, 99)) < zero_pct)
             ? 4'd0 : 4'($urandom_range(1, 15));
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic pulse_full();
    @(negedge clk);
    full_redraw = 1'b1;
    @(negedge clk);
    full_redraw = 1'b0;
  endtask

  task automatic pulse_tile(input int c, input int r);
    @(negedge clk);
    tile_redraw = 1'b1;
    tile_col = 5'(c);
    tile_row = 4'(r);
    @(negedge clk);
    tile_redraw = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int quiet = 0;
    for (int i = 0; i < 20000 && quiet < 4; i++) begin
      @(negedge clk);
      quiet = busy ? 0 : quiet + 1;
    end
    chk(tag, 32'(quiet >= 4), 32'd1);
  endtask

  task automatic cmp_seq(input string tag, input int base);
    int n;
    int e0;
    n = obq.size() - base;
    chk({tag, "_cnt"}, 32'(n), 32'(exq.size()));
    e0 = n_err;
    for (int i = 0; i < n && i < exq.size(); i++) begin
      chk({tag, "_draw"}, obq[base + i], exq[i]);
      if (n_err != e0) break;
    end
    exq.delete();
  endtask

  initial begin
    int base, pd0, lat, c5, r5;
    int tc [5];
    int tr [5];

    for (int i = 0; i < NT; i++) mem[i] = 4'd1;
    repeat (3) @(negedge clk);
    chk("rst_start", 32'(spr_start), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(pass_done), 0);
    chk("rst_ovf", 32'(q_overflow), 0);
    chk("rst_pix", {17'd0, spr_x, spr_y}, 0);
    chk("rst_addr_id", {21'd0, map_addr, spr_id}, 0);
    resetn = 1'b1;

    // full pass over a map with no blanks, plus first-draw latency
    fill_map(0);
    base = obq.size(); pd0 = pd_cnt;
    @(negedge clk);
    full_redraw = 1'b1;
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      full_redraw = 1'b0;
      if (spr_start) begin lat = i; break; end
    end
    chk("latency", 32'(lat), 32'd3);
    wait_idle("full_idle");
    exp_pass();
    chk("full_n", 32'(obq.size() - base), 32'd128);
    chk("full_last", obq[obq.size() - 1], rec(8'd60, 7'd28, mem[NT-1]));
    cmp_seq("full", base);
    chk("full_pd", 32'(pd_cnt - pd0), 32'd1);

    // only one non-blank tile
    do_reset();
    for (int i = 0; i < NT; i++) mem[i] = 4'd0;
    mem[17] = 4'd3;
    base = obq.size(); pd0 = pd_cnt;
    pulse_full();
    wait_idle("one_idle");
    chk("one_n", 32'(obq.size() - base), 32'd1);
    chk("one_draw", obq[obq.size() - 1], rec(8'd4, 7'd4, 4'd3));
    chk("one_pd", 32'(pd_cnt - pd0), 32'd1);

    // random map with blanks
    do_reset();
    fill_map(30);
    base = obq.size(); pd0 = pd_cnt;
    pulse_full();
    wait_idle("rnd_idle");
    exp_pass();
    cmp_seq("rnd", base);
    chk("rnd_pd", 32'(pd_cnt - pd0), 32'd1);

    // five requests during a pass: four queued, one dropped
    do_reset();
    fill_map(0);
    base = obq.size(); pd0 = pd_cnt;
    pulse_full();
    repeat (10) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      tc[k] = $urandom_range(0, COLS - 1);
      tr[k] = $urandom_range(0, ROWS - 1);
      pulse_tile(tc[k], tr[k]);
    end
    chk("ovf_set", 32'(q_overflow), 32'd1);
    wait_idle("ovf_idle");
    exp_pass();
    for (int k = 0; k < 4; k++) exp_tile(tc[k], tr[k]);
    cmp_seq("ovf", base);
    chk("ovf_pd", 32'(pd_cnt - pd0), 32'd5);

    // push on a full queue in the very cycle it pops
    do_reset();
    fill_map(0);
    base = obq.size(); pd0 = pd_cnt;
    pulse_full();
    repeat (10) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      tc[k] = $urandom_range(0, COLS - 1);
      tr[k] = $urandom_range(0, ROWS - 1);
      pulse_tile(tc[k], tr[k]);
    end
    lat = 0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (pass_done) begin lat = 1; break; end
    end
    chk("pp_wait", 32'(lat), 32'd1);
    c5 = $urandom_range(0, COLS - 1);
    r5 = $urandom_range(0, ROWS - 1);
    tile_redraw = 1'b1;
    tile_col = 5'(c5);
    tile_row = 4'(r5);
    @(negedge clk);
    tile_redraw = 1'b0;
    wait_idle("pp_idle");
    chk("pp_ovf", 32'(q_overflow), 32'd0);
    exp_pass();
    for (int k = 0; k < 4; k++) exp_tile(tc[k], tr[k]);
    exp_tile(c5, r5);
    cmp_seq("pp", base);
    chk("pp_pd", 32'(pd_cnt - pd0), 32'd6);

    // repeated full requests coalesce and flush queued tiles
    do_reset();
    fill_map(20);
    base = obq.size(); pd0 = pd_cnt;
    pulse_full();
    repeat (10) @(negedge clk);
    pulse_tile(3, 2);
    pulse_tile(7, 5);
    pulse_full();
    repeat (5) @(negedge clk);
    full_redraw = 1'b1;
    tile_redraw = 1'b1;
    tile_col = 5'd9;
    tile_row = 4'd1;
    @(negedge clk);
    full_redraw = 1'b0;
    tile_redraw = 1'b0;
    wait_idle("co_idle");
    exp_pass();
    exp_pass();
    cmp_seq("co", base);
    chk("co_pd", 32'(pd_cnt - pd0), 32'd2);
    chk("co_ovf", 32'(q_overflow), 32'd0);

    // full and tile requests together while idle
    do_reset();
    fill_map(0);
    base = obq.size(); pd0 = pd_cnt;
    @(negedge clk);
    full_redraw = 1'b1;
    tile_redraw = 1'b1;
    tile_col = 5'd5;
    tile_row = 4'd6;
    @(negedge clk);
    full_redraw = 1'b0;
    tile_redraw = 1'b0;
    wait_idle("sim_idle");
    exp_pass();
    cmp_seq("sim", base);
    chk("sim_pd", 32'(pd_cnt - pd0), 32'd1);

    // out-of-range coordinates are ignored
    do_reset();
    base = obq.size();
    lat = 0;
    pulse_tile(16, 0);
    pulse_tile(0, 8);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (busy) lat = 1;
    end
    chk("oor_busy", 32'(lat), 32'd0);
    chk("oor_ovf", 32'(q_overflow), 32'd0);
    chk("oor_n", 32'(obq.size() - base), 32'd0);

    // reset while drawing tile 40
    do_reset();
    fill_map(0);
    drw_fix = 3;
    base = obq.size();
    pulse_full();
    lat = 0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (obq.size() - base >= 41) begin lat = 1; break; end
    end
    chk("mid_wait", 32'(lat), 32'd1);
    repeat (2) @(negedge clk);
    resetn = 1'b0;
    #1;
    chk("mid_outs",
        {2'd0, spr_start, pass_done, busy, q_overflow,
         spr_x, spr_y, spr_id, map_addr}, 32'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    base = obq.size();
    repeat (30) @(negedge clk);
    chk("mid_quiet", 32'(obq.size() - base), 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);
    drw_fix = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
